sevenseg_mux_display: RTL and testbench
=======================================

SEVENSEG_MUX_DISPLAY -- requirements
Module: sevenseg_mux_display

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 4: number of multiplexed digits; legal range 1..8.
REQ-002 SHALL have parameter REFRESH_DIV, default 100000: Clk cycles per digit slot (1 ms at 100 MHz); legal minimum 2.
REQ-003 SHALL have port Clk  input  1  system clock; all state rising-edge triggered.
REQ-004 SHALL have port Reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port HexVals  input  4*NUM_DIGITS  digit values; digit i = HexVals[4i+3:4i]; digit 0 is rightmost and least significant.
REQ-006 SHALL have port DigitEn  input  NUM_DIGITS  per-digit enable; 0 = digit fully dark.
REQ-007 SHALL have port DpIn  input  NUM_DIGITS  per-digit decimal point request, active-high.
REQ-008 SHALL have port LzEnable  input  1  leading-zero suppression enable.
REQ-009 SHALL have port Seg  output  [0:6]  segments a..g on bits 0..6, active-low.
REQ-010 SHALL have port Dp  output  1  decimal point segment, active-low.
REQ-011 SHALL have port An  output  NUM_DIGITS  digit anodes, active-low, at most one bit low at any time.
REQ-012 SHALL have port FrameStart  output  1  one-cycle pulse on each snapshot update.

Function
REQ-013 SHALL hold a prescaler counting 0..REFRESH_DIV-1 that wraps to 0 after the terminal count.
REQ-014 SHALL hold a digit index Idx that advances on the terminal-count edge, wrapping from NUM_DIGITS-1 to 0.
REQ-015 SHALL capture HexVals, DigitEn, DpIn and LzEnable into a snapshot register on the edge where the prescaler is at terminal count and Idx = NUM_DIGITS-1.
REQ-016 SHALL assert FrameStart for exactly the one cycle following each snapshot edge.
REQ-017 SHALL leave displayed content unaffected by input changes between snapshot edges (no tearing).
REQ-018 SHALL register An, Seg and Dp, computed from Idx and the snapshot, so they follow an Idx change by one cycle.
REQ-019 SHALL decode each 4-bit digit value to Seg (abcdefg, active-low) as follows: 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100, A=0001000, b=1100000, C=0110001, d=1000010, E=0110000, F=0111000.
REQ-020 SHALL treat digit i (i >= 1) as suppressed when snapshot LzEnable=1 and digit i and all higher digits are 0; digit 0 is never suppressed.
REQ-021 SHALL drive the slot for a digit with DigitEn=0 as An bit 1, Seg 1111111 and Dp 1.
REQ-022 SHALL drive the slot for a suppressed digit with DpIn=0 as An bit 1; with DpIn=1, An bit 0, Seg 1111111 and Dp 0.
REQ-023 SHALL drive every other slot with An bit Idx = 0, Seg = decode of the digit value, and Dp = ~DpIn[Idx].
REQ-024 SHALL hold all An bits other than bit Idx at 1.
REQ-025 SHALL, when NUM_DIGITS=1, keep Idx at 0 and raise the snapshot/FrameStart event on every prescaler terminal count.

Reset
REQ-026 SHALL, while Reset=1, asynchronously force prescaler=0, Idx=0, snapshot=all zeros, An=all ones, Seg=1111111, Dp=1 and FrameStart=0.
REQ-027 SHALL, in the first cycle after Reset deasserts, display digit 0 of the zero snapshot (Seg=0000001, An bit 0 low, Dp=1) and first show new inputs only after the first FrameStart.
REQ-028 SHALL, on a mid-frame Reset, abandon the frame immediately and restart at Idx=0 with prescaler=0.

Verification (NUM_DIGITS=4, REFRESH_DIV=4)
REQ-029 SHALL cover reset: hold Reset -> An=1111, Seg=1111111, Dp=1, FrameStart=0; release -> An=1110, Seg=0000001.
REQ-030 SHALL cover scan: HexVals=16'h12AF, DigitEn=1111, LzEnable=0, after the first FrameStart -> An cycles 1110/1101/1011/0111, 4 cycles each, with Seg = F/A/2/1 codes respectively.
REQ-031 SHALL cover suppression: HexVals=16'h0040, LzEnable=1, DpIn=0100 -> digit 3 An stays 1; digit 2 An=0 with Seg=1111111 and Dp=0; digit 1 shows 4; digit 0 shows 0.
REQ-032 SHALL cover anti-tearing: change HexVals from 16'h1111 to 16'h2222 during digit 1's slot -> digits 2 and 3 still show 1; 2 appears only after the next FrameStart.
REQ-033 SHALL cover mid-frame reset: assert Reset during digit 2's slot -> all outputs off asynchronously; after release, scan resumes at An=1110.
REQ-034 SHALL cover digit disable: DigitEn=1011 -> An never reaches 1011, while Seg and Dp stay 1 for that whole 4-cycle slot.

Source files
------------

// File: rtl/sevenseg_mux_display.sv
// Time-multiplexed seven-segment driver: scans a frame snapshot digit by digit,
// with per-digit enable, decimal point and leading-zero suppression.
module sevenseg_mux_display #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 100000
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic [4*NUM_DIGITS-1:0] HexVals,
  input  logic [NUM_DIGITS-1:0]   DigitEn,
  input  logic [NUM_DIGITS-1:0]   DpIn,
  input  logic                    LzEnable,
  output logic [0:6]              Seg,
  output logic                    Dp,
  output logic [NUM_DIGITS-1:0]   An,
  output logic                    FrameStart
);

  localparam int PW    = $clog2(REFRESH_DIV);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  function automatic logic [0:6] hex_to_seg(input logic [3:0] h);
    case (h)
      4'h0: hex_to_seg = 7'b0000001;
      4'h1: hex_to_seg = 7'b1001111;
      4'h2: hex_to_seg = 7'b0010010;
      4'h3: hex_to_seg = 7'b0000110;
      4'h4: hex_to_seg = 7'b1001100;
      4'h5: hex_to_seg = 7'b0100100;
      4'h6: hex_to_seg = 7'b0100000;
      4'h7: hex_to_seg = 7'b0001111;
      4'h8: hex_to_seg = 7'b0000000;
      4'h9: hex_to_seg = 7'b0000100;
      4'hA: hex_to_seg = 7'b0001000;
      4'hB: hex_to_seg = 7'b1100000;
      4'hC: hex_to_seg = 7'b0110001;
      4'hD: hex_to_seg = 7'b1000010;
      4'hE: hex_to_seg = 7'b0110000;
      default: hex_to_seg = 7'b0111000;
    endcase
  endfunction

  logic [PW-1:0]           presc_q, presc_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] hex_q;
  // Enables are held inverted so the all-zero reset snapshot shows every digit.
  logic [NUM_DIGITS-1:0]   dis_q;
  logic [NUM_DIGITS-1:0]   dpi_q;
  logic                    lz_q;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic [0:6]              seg_q, seg_d;
  logic                    dp_q, dp_d;
  logic                    fs_q;

  logic                    tc, last, snap;
  logic                    allz;
  logic [NUM_DIGITS-1:0]   supp, sel;
  logic [3:0]              cur_hex;
  logic                    cur_dis, cur_dp, cur_supp;

  always_comb begin
    tc      = (presc_q == PW'(REFRESH_DIV - 1));
    last    = (idx_q == IDX_W'(NUM_DIGITS - 1));
    snap    = tc && last;
    presc_d = tc ? '0 : presc_q + PW'(1);
    idx_d   = idx_q;
    if (tc) idx_d = last ? '0 : idx_q + IDX_W'(1);
  end

  // Suppression walks down from the top digit; digit 0 is never blanked.
  always_comb begin
    allz     = 1'b1;
    supp     = '0;
    sel      = '0;
    cur_hex  = 4'h0;
    cur_dis  = 1'b0;
    cur_dp   = 1'b0;
    cur_supp = 1'b0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      allz = allz && (hex_q[4*i +: 4] == 4'h0);
      if (i > 0) supp[i] = lz_q && allz;
      if (idx_q == IDX_W'(i)) begin
        sel[i]   = 1'b1;
        cur_hex  = hex_q[4*i +: 4];
        cur_dis  = dis_q[i];
        cur_dp   = dpi_q[i];
        cur_supp = supp[i];
      end
    end
  end

  always_comb begin
    an_d  = '1;
    seg_d = 7'b1111111;
    dp_d  = 1'b1;
    if (!cur_dis) begin
      if (cur_supp) begin
        if (cur_dp) begin
          an_d = ~sel;
          dp_d = 1'b0;
        end
      end else begin
        an_d  = ~sel;
        seg_d = hex_to_seg(cur_hex);
        dp_d  = ~cur_dp;
      end
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      presc_q <= '0;
      idx_q   <= '0;
      hex_q   <= '0;
      dis_q   <= '0;
      dpi_q   <= '0;
      lz_q    <= 1'b0;
      an_q    <= '1;
      seg_q   <= 7'b1111111;
      dp_q    <= 1'b1;
      fs_q    <= 1'b0;
    end else begin
      presc_q <= presc_d;
      idx_q   <= idx_d;
      if (snap) begin
        hex_q <= HexVals;
        dis_q <= ~DigitEn;
        dpi_q <= DpIn;
        lz_q  <= LzEnable;
      end
      an_q  <= an_d;
      seg_q <= seg_d;
      dp_q  <= dp_d;
      fs_q  <= snap;
    end
  end

  assign An         = an_q;
  assign Seg        = seg_q;
  assign Dp         = dp_q;
  assign FrameStart = fs_q;

endmodule

// File: tb/tb_sevenseg_mux_display.sv
// Directed bench for sevenseg_mux_display: 4-digit instance (refresh 4) plus a
// 1-digit instance (refresh 2).
module tb_sevenseg_mux_display;

  localparam logic [6:0] S0 = 7'b0000001, S1 = 7'b1001111, S2 = 7'b0010010,
                         S3 = 7'b0000110, S4 = 7'b1001100, S5 = 7'b0100100,
                         S6 = 7'b0100000, S7 = 7'b0001111, S8 = 7'b0000000,
                         S9 = 7'b0000100, SA = 7'b0001000, SB = 7'b1100000,
                         SC = 7'b0110001, SD = 7'b1000010, SE = 7'b0110000,
                         SF = 7'b0111000, SX = 7'b1111111;

  logic        Clk, Reset;
  logic [15:0] HexVals;
  logic [3:0]  DigitEn, DpIn;
  logic        LzEnable;
  logic [0:6]  Seg;
  logic        Dp, FrameStart;
  logic [3:0]  An;

  logic [3:0]  h1;
  logic        en1, dpi1, lz1;
  logic [0:6]  Seg1;
  logic        Dp1, FS1;
  logic        An1;

  int n_vec = 0;
  int n_bad = 0;

  sevenseg_mux_display #(.NUM_DIGITS(4), .REFRESH_DIV(4)) u0 (
    .Clk(Clk), .Reset(Reset), .HexVals(HexVals), .DigitEn(DigitEn),
    .DpIn(DpIn), .LzEnable(LzEnable), .Seg(Seg), .Dp(Dp), .An(An),
    .FrameStart(FrameStart)
  );

  sevenseg_mux_display #(.NUM_DIGITS(1), .REFRESH_DIV(2)) u1 (
    .Clk(Clk), .Reset(Reset), .HexVals(h1), .DigitEn(en1),
    .DpIn(dpi1), .LzEnable(lz1), .Seg(Seg1), .Dp(Dp1), .An(An1),
    .FrameStart(FS1)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  typedef struct {
    logic [15:0] hex;
    logic [3:0]  en;
    logic [3:0]  dp;
    logic        lz;
    logic [15:0] an;   // {d3,d2,d1,d0}
    logic [27:0] seg;  // {d3,d2,d1,d0}
    logic [3:0]  dpo;  // {d3,d2,d1,d0}
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic wait_frame();
    int n = 0;
    do begin
      @(negedge Clk);
      n++;
    end while (!FrameStart && n < 40);
    chk("frame_start_seen", {31'b0, FrameStart}, 32'd1);
  endtask

  task automatic check_slot(input string tag, input int k, input logic [3:0] ean,
                            input logic [6:0] eseg, input logic edp);
    logic efs;
    efs = (k == 15);
    @(negedge Clk);
    chk({tag, "_an"},  {28'b0, An}, {28'b0, ean});
    chk({tag, "_seg"}, {25'b0, Seg}, {25'b0, eseg});
    chk({tag, "_dp"},  {31'b0, Dp}, {31'b0, edp});
    chk({tag, "_fs"},  {31'b0, FrameStart}, {31'b0, efs});
  endtask

  initial begin
    vecs[0] = '{16'h12AF, 4'hF, 4'b0000, 1'b0, 16'h7BDE, {S1, S2, SA, SF}, 4'b1111};
    vecs[1] = '{16'h0040, 4'hF, 4'b0100, 1'b1, 16'hFBDE, {SX, SX, S4, S0}, 4'b1011};
    vecs[2] = '{16'h1234, 4'b1011, 4'b0001, 1'b0, 16'h7FDE, {S1, SX, S3, S4}, 4'b1110};
    vecs[3] = '{16'h0000, 4'hF, 4'b0000, 1'b1, 16'hFFFE, {SX, SX, SX, S0}, 4'b1111};
    vecs[4] = '{16'h00A0, 4'hF, 4'b1000, 1'b0, 16'h7BDE, {S0, S0, SA, S0}, 4'b0111};
    vecs[5] = '{16'hEDCB, 4'hF, 4'b0000, 1'b1, 16'h7BDE, {SE, SD, SC, SB}, 4'b1111};
    vecs[6] = '{16'h5678, 4'hF, 4'b0000, 1'b0, 16'h7BDE, {S5, S6, S7, S8}, 4'b1111};
    vecs[7] = '{16'h9003, 4'hF, 4'b0000, 1'b1, 16'h7BDE, {S9, S0, S0, S3}, 4'b1111};

    Reset = 1'b1;
    HexVals = 16'h12AF; DigitEn = 4'hF; DpIn = 4'h0; LzEnable = 1'b0;
    h1 = 4'h0; en1 = 1'b1; dpi1 = 1'b0; lz1 = 1'b0;

    // Reset state, then zero snapshot shown before the first frame.
    repeat (3) @(negedge Clk);
    chk("rst_an",  {28'b0, An}, 32'hF);
    chk("rst_seg", {25'b0, Seg}, {25'b0, SX});
    chk("rst_dp",  {31'b0, Dp}, 32'd1);
    chk("rst_fs",  {31'b0, FrameStart}, 32'd0);
    Reset = 1'b0;
    @(negedge Clk);
    chk("rel_an",  {28'b0, An}, 32'hE);
    chk("rel_seg", {25'b0, Seg}, {25'b0, S0});
    chk("rel_dp",  {31'b0, Dp}, 32'd1);
    repeat (4) @(negedge Clk);
    chk("pre_d1_an",  {28'b0, An}, 32'hD);
    chk("pre_d1_seg", {25'b0, Seg}, {25'b0, S0});

    // Table-driven full frames.
    for (int v = 0; v < 8; v++) begin
      HexVals = vecs[v].hex; DigitEn = vecs[v].en;
      DpIn = vecs[v].dp; LzEnable = vecs[v].lz;
      wait_frame();
      for (int k = 0; k < 16; k++)
        check_slot($sformatf("v%0d_d%0d", v, k / 4), k, vecs[v].an[(k/4)*4 +: 4],
                   vecs[v].seg[(k/4)*7 +: 7], vecs[v].dpo[k/4]);
    end

    // No tearing: change input during digit 1's slot.
    HexVals = 16'h1111; DigitEn = 4'hF; DpIn = 4'h0; LzEnable = 1'b0;
    wait_frame();
    for (int k = 0; k < 16; k++) begin
      logic [3:0] a;
      a = ~(4'b0001 << (k / 4));
      check_slot("tear_old", k, a, S1, 1'b1);
      if (k == 4) HexVals = 16'h2222;
    end
    for (int k = 0; k < 16; k++) begin
      logic [3:0] a;
      a = ~(4'b0001 << (k / 4));
      check_slot("tear_new", k, a, S2, 1'b1);
    end

    // Asynchronous reset in the middle of digit 2's slot.
    repeat (9) @(negedge Clk);
    chk("mid_pre_an", {28'b0, An}, 32'hB);
    #1 Reset = 1'b1;
    #1;
    chk("mid_rst_an",  {28'b0, An}, 32'hF);
    chk("mid_rst_seg", {25'b0, Seg}, {25'b0, SX});
    chk("mid_rst_dp",  {31'b0, Dp}, 32'd1);
    chk("mid_rst_fs",  {31'b0, FrameStart}, 32'd0);
    @(negedge Clk);
    chk("mid_hold_an", {28'b0, An}, 32'hF);
    Reset = 1'b0;
    @(negedge Clk);
    chk("mid_rel_an",  {28'b0, An}, 32'hE);
    chk("mid_rel_seg", {25'b0, Seg}, {25'b0, S0});
    chk("mid_rel_dp",  {31'b0, Dp}, 32'd1);
    repeat (3) @(negedge Clk);
    chk("mid_d0_end_an", {28'b0, An}, 32'hE);
    @(negedge Clk);
    chk("mid_d1_an", {28'b0, An}, 32'hD);

    // Single-digit instance: snapshot on every terminal count.
    h1 = 4'h7; en1 = 1'b1; dpi1 = 1'b1; lz1 = 1'b1;
    repeat (4) @(negedge Clk);
    begin
      logic prev, expf;
      int   cnt;
      cnt  = 0;
      prev = FS1;
      for (int i = 0; i < 6; i++) begin
        @(negedge Clk);
        expf = ~prev;
        chk("n1_fs_toggle", {31'b0, FS1}, {31'b0, expf});
        if (FS1) cnt++;
        prev = FS1;
      end
      chk("n1_fs_count", cnt, 32'd3);
    end
    chk("n1_an",  {31'b0, An1}, 32'd0);
    chk("n1_seg", {25'b0, Seg1}, {25'b0, S7});
    chk("n1_dp",  {31'b0, Dp1}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
